// File: rtl/fwft_prefetch_ctrl_if.sv
// Read-side bundle of the FWFT prefetch adapter: upstream FIFO/RAM handshake plus consumer view.
interface fwft_prefetch_ctrl_if #(
  parameter int RWIDTH = 32,
  parameter int LVLW   = 4
);
  logic              fifo_empty;
  logic              fifo_aempty;
  logic              fifo_rd_en;
  logic [RWIDTH-1:0] fifo_dout;
  logic              rd_en;
  logic [RWIDTH-1:0] dout;
  logic              dvld;
  logic              empty;
  logic              aempty;
  logic [LVLW-1:0]   level;
  logic              underflow;

  modport slave (
    input  fifo_empty, fifo_aempty, fifo_dout, rd_en,
    output fifo_rd_en, dout, dvld, empty, aempty, level, underflow
  );

  modport master (
    output fifo_empty, fifo_aempty, fifo_dout, rd_en,
    input  fifo_rd_en, dout, dvld, empty, aempty, level, underflow
  );
endinterface

// File: rtl/fwft_prefetch_ctrl.sv
// First-word-fall-through read adapter: credit-limited prefetch from a pipelined RAM
// into a skid buffer feeding a registered output word.
module fwft_prefetch_ctrl #(
  parameter int RWIDTH    = 32,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 4,
  parameter int READ_LOW  = 0,
  parameter int AE_THR    = 1,
  parameter int LVLW      = 4
) (
  input  logic                pos_rclk,
  input  logic                aresetn_rclk,
  input  logic                sresetn_rclk,
  fwft_prefetch_ctrl_if.slave bus
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = LVLW + 2;
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1'b1);
  localparam logic [PW:0]     CNT_ONE    = {{PW{1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CREDIT_CAP = CW'(BUF_DEPTH + 1);
  localparam logic [LVLW-1:0] AE_LEVEL   = LVLW'(AE_THR);

  function automatic logic [CW-1:0] count_tags(input logic [RD_LAT-1:0] tags);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      n = n + {{(CW-1){1'b0}}, tags[i]};
    end
    return n;
  endfunction

  logic [RD_LAT-1:0] tag_r;
  logic [RWIDTH-1:0] mem_r [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW:0]       buf_cnt_r;
  logic [RWIDTH-1:0] dout_r;
  logic              dvld_r;
  logic              empty_r;
  logic              underflow_r;
  logic [LVLW-1:0]   level_r;

  logic              re_p_s;
  logic              pop_s;
  logic              rd_req_s;
  logic              arrive_s;
  logic              buf_has_s;
  logic              load_s;
  logic              buf_rd_s;
  logic              buf_wr_s;
  logic              dvld_nxt_s;
  logic [CW-1:0]     credits_s;
  logic [PW:0]       buf_cnt_nxt_s;
  logic [LVLW-1:0]   level_nxt_s;

  // Per-cycle pop, credit and output-load decisions.
  always_comb begin
    if (READ_LOW != 0) begin
      re_p_s = ~bus.rd_en;
    end else begin
      re_p_s = bus.rd_en;
    end
    pop_s     = re_p_s & dvld_r;
    // A same-cycle pop returns its credit immediately so the pipe stays full under streaming.
    credits_s = count_tags(tag_r) + CW'(buf_cnt_r) + CW'(dvld_r) - CW'(pop_s);
    rd_req_s  = ~bus.fifo_empty & (credits_s < CREDIT_CAP);
    arrive_s  = tag_r[RD_LAT-1];
    buf_has_s = (buf_cnt_r != {(PW+1){1'b0}});
    load_s    = (~dvld_r | pop_s) & (buf_has_s | arrive_s);
    buf_rd_s  = load_s & buf_has_s;
    buf_wr_s  = arrive_s & ~(load_s & ~buf_has_s);
    if (load_s) begin
      dvld_nxt_s = 1'b1;
    end else if (pop_s) begin
      dvld_nxt_s = 1'b0;
    end else begin
      dvld_nxt_s = dvld_r;
    end
    if (buf_wr_s & ~buf_rd_s) begin
      buf_cnt_nxt_s = buf_cnt_r + CNT_ONE;
    end else if (buf_rd_s & ~buf_wr_s) begin
      buf_cnt_nxt_s = buf_cnt_r - CNT_ONE;
    end else begin
      buf_cnt_nxt_s = buf_cnt_r;
    end
    level_nxt_s = LVLW'(buf_cnt_nxt_s) + LVLW'(dvld_nxt_s);
  end

  // Return-path tags, skid pointers and the registered consumer outputs.
  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      tag_r       <= {RD_LAT{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      buf_cnt_r   <= {(PW+1){1'b0}};
      dout_r      <= {RWIDTH{1'b0}};
      dvld_r      <= 1'b0;
      empty_r     <= 1'b1;
      level_r     <= {LVLW{1'b0}};
      underflow_r <= 1'b0;
    end else if (!sresetn_rclk) begin
      tag_r       <= {RD_LAT{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      buf_cnt_r   <= {(PW+1){1'b0}};
      dout_r      <= {RWIDTH{1'b0}};
      dvld_r      <= 1'b0;
      empty_r     <= 1'b1;
      level_r     <= {LVLW{1'b0}};
      underflow_r <= 1'b0;
    end else begin
      tag_r[0] <= rd_req_s;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
      if (buf_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (buf_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      buf_cnt_r <= buf_cnt_nxt_s;
      if (load_s) begin
        dout_r <= buf_has_s ? mem_r[rd_ptr_r] : bus.fifo_dout;
      end
      dvld_r      <= dvld_nxt_s;
      empty_r     <= ~dvld_nxt_s;
      level_r     <= level_nxt_s;
      underflow_r <= re_p_s & ~dvld_r;
    end
  end

  // Skid storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge pos_rclk) begin
    if (buf_wr_s) begin
      mem_r[wr_ptr_r] <= bus.fifo_dout;
    end
  end

  assign bus.fifo_rd_en = rd_req_s;
  assign bus.dout       = dout_r;
  assign bus.dvld       = dvld_r;
  assign bus.empty      = empty_r;
  assign bus.level      = level_r;
  assign bus.underflow  = underflow_r;
  assign bus.aempty     = bus.fifo_aempty | (level_r <= AE_LEVEL);

endmodule

// File: tb/tb_fwft_prefetch_ctrl.sv
// Bench for fwft_prefetch_ctrl: hand-derived vector table, directed corner sequences and
// a randomized run against a queue-based model of the adapter's observable behaviour.
module tb_fwft_prefetch_ctrl;
  localparam int RWIDTH    = 32;
  localparam int RD_LAT    = 2;
  localparam int BUF_DEPTH = 4;
  localparam int READ_LOW  = 0;
  localparam int AE_THR    = 2;
  localparam int LVLW      = 4;
  localparam int NWORDS    = 16384;

  logic pos_rclk = 1'b0;
  logic aresetn_rclk;
  logic sresetn_rclk;

  always #5 pos_rclk = ~pos_rclk;

  fwft_prefetch_ctrl_if #(.RWIDTH(RWIDTH), .LVLW(LVLW)) bus ();

  fwft_prefetch_ctrl #(
    .RWIDTH(RWIDTH), .RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH),
    .READ_LOW(READ_LOW), .AE_THR(AE_THR), .LVLW(LVLW)
  ) dut (
    .pos_rclk(pos_rclk),
    .aresetn_rclk(aresetn_rclk),
    .sresetn_rclk(sresetn_rclk),
    .bus(bus)
  );

  typedef struct {
    int              due;
    logic [RWIDTH-1:0] data;
  } xfer_t;

  typedef struct {
    logic       re;
    logic       frd;
    logic       dvld;
    logic [7:0] dout;
    logic [3:0] level;
    logic       aempty;
    logic       uf;
  } vec_t;

  xfer_t             env_pipe[$];
  xfer_t             mdl_pipe[$];
  logic [RWIDTH-1:0] mdl_local[$];
  logic [RWIDTH-1:0] words [NWORDS];
  vec_t              vec [22];
  int                n_words;
  int                env_idx;
  int                mdl_idx;
  int                cyc;
  logic              mdl_uf;
  int                n_checks;
  int                n_pass;

  task automatic chk(input string name, input logic [RWIDTH-1:0] act, input logic [RWIDTH-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc=%0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic drive_re(input logic re);
    return (READ_LOW != 0) ? ~re : re;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check combinational outputs, advance.
  task automatic do_cycle(input logic re, input logic hold_empty, input logic fae,
                          input logic srst, output logic frd);
    logic  m_pop;
    logic  m_frd;
    int    credits;
    xfer_t x;
    chk("dvld", RWIDTH'(bus.dvld), RWIDTH'(mdl_local.size() != 0));
    chk("empty", RWIDTH'(bus.empty), RWIDTH'(mdl_local.size() == 0));
    chk("level", RWIDTH'(bus.level), RWIDTH'(mdl_local.size()));
    chk("underflow", RWIDTH'(bus.underflow), RWIDTH'(mdl_uf));
    if (mdl_local.size() != 0) chk("dout", bus.dout, mdl_local[0]);

    bus.rd_en       = drive_re(re);
    bus.fifo_empty  = hold_empty | (env_idx >= n_words);
    bus.fifo_aempty = fae;
    if (env_pipe.size() != 0 && env_pipe[0].due == cyc) bus.fifo_dout = env_pipe[0].data;
    else bus.fifo_dout = $urandom;
    sresetn_rclk = ~srst;
    #1;
    m_pop   = re & (mdl_local.size() != 0);
    credits = mdl_pipe.size() + mdl_local.size() - int'(m_pop);
    m_frd   = ~bus.fifo_empty & (credits < BUF_DEPTH + 1);
    frd     = bus.fifo_rd_en;
    chk("fifo_rd_en", RWIDTH'(frd), RWIDTH'(m_frd));
    chk("aempty", RWIDTH'(bus.aempty), RWIDTH'(fae | (mdl_local.size() <= AE_THR)));

    @(posedge pos_rclk);
    // upstream RAM answers the requests the DUT actually made
    if (env_pipe.size() != 0 && env_pipe[0].due == cyc) void'(env_pipe.pop_front());
    if (frd) begin
      env_pipe.push_back('{cyc + RD_LAT, words[env_idx % NWORDS]});
      env_idx++;
    end
    if (srst) begin
      mdl_local.delete();
      mdl_pipe.delete();
      mdl_uf = 1'b0;
      if (m_frd) mdl_idx++;
    end else begin
      mdl_uf = re & (mdl_local.size() == 0);
      if (m_pop) void'(mdl_local.pop_front());
      if (mdl_pipe.size() != 0 && mdl_pipe[0].due == cyc) begin
        x = mdl_pipe.pop_front();
        mdl_local.push_back(x.data);
      end
      if (m_frd) begin
        mdl_pipe.push_back('{cyc + RD_LAT, words[mdl_idx % NWORDS]});
        mdl_idx++;
      end
    end
    cyc++;
    @(negedge pos_rclk);
    sresetn_rclk = 1'b1;
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
  task automatic reset_and_check();
    aresetn_rclk    = 1'b0;
    bus.fifo_empty  = 1'b1;
    bus.fifo_aempty = 1'b0;
    bus.rd_en       = drive_re(1'b0);
    #1;
    chk("rst_dout", bus.dout, 32'h0);
    chk("rst_dvld", RWIDTH'(bus.dvld), 32'h0);
    chk("rst_empty", RWIDTH'(bus.empty), 32'h1);
    chk("rst_level", RWIDTH'(bus.level), 32'h0);
    chk("rst_underflow", RWIDTH'(bus.underflow), 32'h0);
    chk("rst_aempty", RWIDTH'(bus.aempty), 32'h1);
    mdl_local.delete();
    mdl_pipe.delete();
    mdl_uf = 1'b0;
    @(posedge pos_rclk);
    if (env_pipe.size() != 0 && env_pipe[0].due == cyc) void'(env_pipe.pop_front());
    cyc++;
    @(negedge pos_rclk);
    aresetn_rclk = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic frd;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    env_idx  = 0;
    mdl_idx  = 0;
    mdl_uf   = 1'b0;
    for (int i = 0; i < NWORDS; i++) words[i] = (i < 10) ? RWIDTH'(i + 1) : $urandom;
    n_words = 10;

    // re, fifo_rd_en, dvld, dout, level, aempty, underflow (10 words 0x1..0xA upstream)
    vec[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 1'b1, 8'h01, 4'd2, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 8'h01, 4'd3, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 1'b1, 8'h01, 4'd4, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 8'h01, 4'd5, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 1'b1, 1'b1, 8'h01, 4'd5, 1'b0, 1'b0};
    vec[9]  = '{1'b1, 1'b1, 1'b1, 8'h02, 4'd4, 1'b0, 1'b0};
    vec[10] = '{1'b1, 1'b1, 1'b1, 8'h03, 4'd3, 1'b0, 1'b0};
    vec[11] = '{1'b1, 1'b1, 1'b1, 8'h04, 4'd3, 1'b0, 1'b0};
    vec[12] = '{1'b1, 1'b1, 1'b1, 8'h05, 4'd3, 1'b0, 1'b0};
    vec[13] = '{1'b1, 1'b0, 1'b1, 8'h06, 4'd3, 1'b0, 1'b0};
    vec[14] = '{1'b1, 1'b0, 1'b1, 8'h07, 4'd3, 1'b0, 1'b0};
    vec[15] = '{1'b1, 1'b0, 1'b1, 8'h08, 4'd3, 1'b0, 1'b0};
    vec[16] = '{1'b1, 1'b0, 1'b1, 8'h09, 4'd2, 1'b1, 1'b0};
    vec[17] = '{1'b1, 1'b0, 1'b1, 8'h0A, 4'd1, 1'b1, 1'b0};
    vec[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[19] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};
    vec[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1};
    vec[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0};

    sresetn_rclk    = 1'b1;
    aresetn_rclk    = 1'b0;
    bus.fifo_empty  = 1'b1;
    bus.fifo_aempty = 1'b0;
    bus.fifo_dout   = '0;
    bus.rd_en       = drive_re(1'b0);
    @(negedge pos_rclk);
    reset_and_check();

    // fill without popping, then stream out, then underflow while empty
    for (int i = 0; i < 22; i++) begin
      chk("tbl_dvld", RWIDTH'(bus.dvld), RWIDTH'(vec[i].dvld));
      chk("tbl_level", RWIDTH'(bus.level), RWIDTH'(vec[i].level));
      chk("tbl_aempty", RWIDTH'(bus.aempty), RWIDTH'(vec[i].aempty));
      chk("tbl_underflow", RWIDTH'(bus.underflow), RWIDTH'(vec[i].uf));
      if (vec[i].dvld) chk("tbl_dout", bus.dout, RWIDTH'(vec[i].dout));
      do_cycle(vec[i].re, 1'b0, 1'b0, 1'b0, frd);
      chk("tbl_fifo_rd_en", RWIDTH'(frd), RWIDTH'(vec[i].frd));
    end

    // async reset with level 3 and two words in flight; late returns must be ignored
    n_words = NWORDS;
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, frd);
    chk("pre_rst_level", RWIDTH'(bus.level), 32'd3);
    reset_and_check();
    for (int i = 0; i < 11; i++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, frd);
    chk("refill_level", RWIDTH'(bus.level), 32'd5);

    // fifo_aempty overrides level; then pop 5 -> 2 and watch aempty rise
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0, frd);
    chk("fae_forced", RWIDTH'(bus.aempty), 32'h1);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, frd);
    chk("fae_clear", RWIDTH'(bus.aempty), 32'h0);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, frd);
    chk("pop_level4", RWIDTH'(bus.level), 32'd4);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, frd);
    chk("pop_level3_ae", RWIDTH'(bus.aempty), 32'h0);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, frd);
    chk("pop_level2", RWIDTH'(bus.level), 32'd2);
    chk("pop_level2_ae", RWIDTH'(bus.aempty), 32'h1);

    // synchronous reset clears held data
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, frd);
    chk("srst_dvld", RWIDTH'(bus.dvld), 32'h0);
    chk("srst_level", RWIDTH'(bus.level), 32'h0);

    for (int i = 0; i < 10000; i++) begin
      do_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
               $urandom_range(0, 99) < 10, $urandom_range(0, 999) < 5, frd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
